// File: rtl/rs_alu_pkg.sv
// Shared definitions for the ALU reservation station.
// This package holds the operation encodings and the default datapath, tag and station sizes.
package rs_alu_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TAG_W   = 4;
    localparam int RS_SIZE = 8;
    localparam int OP_W    = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_ADDI  = 5'd10,
        OP_ANDI  = 5'd11,
        OP_ORI   = 5'd12,
        OP_XORI  = 5'd13,
        OP_SLLI  = 5'd14,
        OP_SRLI  = 5'd15,
        OP_SRAI  = 5'd16,
        OP_SLTI  = 5'd17,
        OP_SLTIU = 5'd18,
        OP_LUI   = 5'd19,
        OP_AUIPC = 5'd20
    } op_e;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder.
// The station uses one instance to find a free slot and another to pick the entry to dispatch.
module rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station. It holds issued instructions until their operands arrive on the CDB,
// then dispatches the lowest-index ready entry each cycle through registered ALU outputs.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = rs_alu_pkg::RS_SIZE,
    parameter int TAG_W   = rs_alu_pkg::TAG_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              issue_valid,
    input  op_e               issue_op,
    input  logic [ADDR_W-1:0] issue_pc,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              issue_qj_busy,
    input  logic              issue_qk_busy,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [TAG_W-1:0]  issue_dest,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              alu_valid,
    output op_e               alu_op,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [ADDR_W-1:0] alu_pc,
    output logic [DATA_W-1:0] alu_imm,
    output logic [TAG_W-1:0]  alu_dest
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q,   busy_d;
    logic [RS_SIZE-1:0] qjBusy_q, qjBusy_d;
    logic [RS_SIZE-1:0] qkBusy_q, qkBusy_d;
    op_e                op_q   [RS_SIZE];
    op_e                op_d   [RS_SIZE];
    logic [DATA_W-1:0]  vj_q   [RS_SIZE];
    logic [DATA_W-1:0]  vj_d   [RS_SIZE];
    logic [DATA_W-1:0]  vk_q   [RS_SIZE];
    logic [DATA_W-1:0]  vk_d   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_d   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_d   [RS_SIZE];
    logic [ADDR_W-1:0]  pc_q   [RS_SIZE];
    logic [ADDR_W-1:0]  pc_d   [RS_SIZE];
    logic [DATA_W-1:0]  imm_q  [RS_SIZE];
    logic [DATA_W-1:0]  imm_d  [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic              aluValid_q, aluValid_d;
    op_e               aluOp_q,    aluOp_d;
    logic [DATA_W-1:0] aluRs1_q,   aluRs1_d;
    logic [DATA_W-1:0] aluRs2_q,   aluRs2_d;
    logic [ADDR_W-1:0] aluPc_q,    aluPc_d;
    logic [DATA_W-1:0] aluImm_q,   aluImm_d;
    logic [TAG_W-1:0]  aluDest_q,  aluDest_d;

    logic [RS_SIZE-1:0] readyVec;
    logic [IDX_W-1:0]   freeIdx, readyIdx;
    logic               freeFound, readyFound;
    logic               issueJHit, issueKHit;

    // Readiness comes from registered state only, so a same-cycle issue or wake-up waits one cycle.
    assign readyVec = busy_q & ~qjBusy_q & ~qkBusy_q;

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_freeSelect (
        .req_i   (~busy_q),
        .idx_o   (freeIdx),
        .found_o (freeFound)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_readySelect (
        .req_i   (readyVec),
        .idx_o   (readyIdx),
        .found_o (readyFound)
    );

    assign full      = ~freeFound;
    assign issueJHit = issue_qj_busy && cdb_valid && (issue_qj == cdb_tag);
    assign issueKHit = issue_qk_busy && cdb_valid && (issue_qk == cdb_tag);

    always_comb begin
        busy_d     = busy_q;
        qjBusy_d   = qjBusy_q;
        qkBusy_d   = qkBusy_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        dest_d     = dest_q;
        aluValid_d = aluValid_q;
        aluOp_d    = aluOp_q;
        aluRs1_d   = aluRs1_q;
        aluRs2_d   = aluRs2_q;
        aluPc_d    = aluPc_q;
        aluImm_d   = aluImm_q;
        aluDest_d  = aluDest_q;

        if (rdy_in) begin
            if (flush) begin
                busy_d     = '0;
                aluValid_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (cdb_valid && busy_q[i] && qjBusy_q[i] && (qj_q[i] == cdb_tag)) begin
                        vj_d[i]     = cdb_value;
                        qjBusy_d[i] = 1'b0;
                    end
                    if (cdb_valid && busy_q[i] && qkBusy_q[i] && (qk_q[i] == cdb_tag)) begin
                        vk_d[i]     = cdb_value;
                        qkBusy_d[i] = 1'b0;
                    end
                end

                aluValid_d = readyFound;
                if (readyFound) begin
                    aluOp_d          = op_q[readyIdx];
                    aluRs1_d         = vj_q[readyIdx];
                    aluRs2_d         = vk_q[readyIdx];
                    aluPc_d          = pc_q[readyIdx];
                    aluImm_d         = imm_q[readyIdx];
                    aluDest_d        = dest_q[readyIdx];
                    busy_d[readyIdx] = 1'b0;
                end

                // The free slot is always distinct from the dispatching entry, since one is idle and the other busy.
                if (issue_valid && !full) begin
                    busy_d[freeIdx]   = 1'b1;
                    op_d[freeIdx]     = issue_op;
                    pc_d[freeIdx]     = issue_pc;
                    imm_d[freeIdx]    = issue_imm;
                    dest_d[freeIdx]   = issue_dest;
                    qj_d[freeIdx]     = issue_qj;
                    qk_d[freeIdx]     = issue_qk;
                    qjBusy_d[freeIdx] = issue_qj_busy && !issueJHit;
                    qkBusy_d[freeIdx] = issue_qk_busy && !issueKHit;
                    vj_d[freeIdx]     = issueJHit ? cdb_value : issue_vj;
                    vk_d[freeIdx]     = issueKHit ? cdb_value : issue_vk;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            qjBusy_q   <= '0;
            qkBusy_q   <= '0;
            op_q       <= '{default: OP_ADD};
            vj_q       <= '{default: '0};
            vk_q       <= '{default: '0};
            qj_q       <= '{default: '0};
            qk_q       <= '{default: '0};
            pc_q       <= '{default: '0};
            imm_q      <= '{default: '0};
            dest_q     <= '{default: '0};
            aluValid_q <= 1'b0;
            aluOp_q    <= OP_ADD;
            aluRs1_q   <= '0;
            aluRs2_q   <= '0;
            aluPc_q    <= '0;
            aluImm_q   <= '0;
            aluDest_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            qjBusy_q   <= qjBusy_d;
            qkBusy_q   <= qkBusy_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            dest_q     <= dest_d;
            aluValid_q <= aluValid_d;
            aluOp_q    <= aluOp_d;
            aluRs1_q   <= aluRs1_d;
            aluRs2_q   <= aluRs2_d;
            aluPc_q    <= aluPc_d;
            aluImm_q   <= aluImm_d;
            aluDest_q  <= aluDest_d;
        end
    end

    assign alu_valid = aluValid_q;
    assign alu_op    = aluOp_q;
    assign alu_rs1   = aluRs1_q;
    assign alu_rs2   = aluRs2_q;
    assign alu_pc    = aluPc_q;
    assign alu_imm   = aluImm_q;
    assign alu_dest  = aluDest_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu. Expected dispatches are queued when an instruction is issued,
// and a monitor pops and compares them whenever the station hands a new operation to the ALU.
module tb_rs_alu;
    import rs_alu_pkg::*;

    typedef struct {
        op_e         op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  dest;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, issue_valid;
    op_e         issue_op;
    logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
    logic        issue_qj_busy, issue_qk_busy;
    logic [3:0]  issue_qj, issue_qk, issue_dest;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        alu_valid;
    op_e         alu_op;
    logic [31:0] alu_rs1, alu_rs2, alu_pc, alu_imm;
    logic [3:0]  alu_dest;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sbQueue[$];
    exp_t mon;
    logic rdyAtEdge;

    rs_alu #(.RS_SIZE(8), .TAG_W(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_pc      (issue_pc),
        .issue_imm     (issue_imm),
        .issue_vj      (issue_vj),
        .issue_vk      (issue_vk),
        .issue_qj_busy (issue_qj_busy),
        .issue_qk_busy (issue_qk_busy),
        .issue_qj      (issue_qj),
        .issue_qk      (issue_qk),
        .issue_dest    (issue_dest),
        .full          (full),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .alu_valid     (alu_valid),
        .alu_op        (alu_op),
        .alu_rs1       (alu_rs1),
        .alu_rs2       (alu_rs2),
        .alu_pc        (alu_pc),
        .alu_imm       (alu_imm),
        .alu_dest      (alu_dest)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pushExp(input op_e op, input logic [31:0] rs1, rs2, pc, imm, input logic [3:0] dest);
        exp_t e;
        e.op   = op;
        e.rs1  = rs1;
        e.rs2  = rs2;
        e.pc   = pc;
        e.imm  = imm;
        e.dest = dest;
        sbQueue.push_back(e);
    endtask

    task automatic driveIssue(input op_e op, input logic [31:0] pc, imm, vj, vk,
                              input logic qjb, input logic [3:0] qj,
                              input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_pc      = pc;
        issue_imm     = imm;
        issue_vj      = vj;
        issue_vk      = vk;
        issue_qj_busy = qjb;
        issue_qj      = qj;
        issue_qk_busy = qkb;
        issue_qk      = qk;
        issue_dest    = dest;
    endtask

    task automatic applyStimulus(input op_e op, input logic [31:0] pc, imm, vj, vk,
                                 input logic qjb, input logic [3:0] qj,
                                 input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
        driveIssue(op, pc, imm, vj, vk, qjb, qj, qkb, qk, dest);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = value;
        tick();
        cdb_valid = 1'b0;
    endtask

    // A dispatch is new only when the edge that produced it saw the station enabled.
    always begin
        @(posedge clk_in);
        rdyAtEdge = rdy_in & rst_in;
        #1;
        if (rdyAtEdge && alu_valid) begin
            checkOutput("dispatch_expected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                mon = sbQueue.pop_front();
                checkOutput("alu_op",   32'(alu_op),   32'(mon.op));
                checkOutput("alu_rs1",  alu_rs1,       mon.rs1);
                checkOutput("alu_rs2",  alu_rs2,       mon.rs2);
                checkOutput("alu_pc",   alu_pc,        mon.pc);
                checkOutput("alu_imm",  alu_imm,       mon.imm);
                checkOutput("alu_dest", 32'(alu_dest), 32'(mon.dest));
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = OP_ADD;
        issue_pc      = '0;
        issue_imm     = '0;
        issue_vj      = '0;
        issue_vk      = '0;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
        issue_qj      = '0;
        issue_qk      = '0;
        issue_dest    = '0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_value     = '0;

        tick();
        tick();
        checkOutput("reset_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("reset_full",      32'(full),      32'd0);
        checkOutput("reset_alu_rs1",   alu_rs1,        32'd0);
        checkOutput("reset_alu_imm",   alu_imm,        32'd0);
        checkOutput("reset_alu_dest",  32'(alu_dest),  32'd0);
        rst_in = 1'b1;
        tick();

        // Both operands ready: dispatch the cycle after issue.
        pushExp(OP_ADDI, 32'd5, 32'd0, 32'h100, 32'd7, 4'd3);
        applyStimulus(OP_ADDI, 32'h100, 32'd7, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        checkOutput("addi_no_same_cycle", 32'(alu_valid), 32'd0);
        tick();
        checkOutput("addi_dispatch", 32'(alu_valid), 32'd1);
        checkOutput("addi_freed_full", 32'(full), 32'd0);
        tick();
        checkOutput("addi_idle_after", 32'(alu_valid), 32'd0);

        // Pending rs1 woken by a later broadcast.
        applyStimulus(OP_ADD, 32'h104, 32'd0, 32'hBAD, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        checkOutput("add_waits", 32'(alu_valid), 32'd0);
        pushExp(OP_ADD, 32'd10, 32'd1, 32'h104, 32'd0, 4'd5);
        broadcast(4'd2, 32'd10);
        checkOutput("add_capture_cycle", 32'(alu_valid), 32'd0);
        tick();
        checkOutput("add_dispatch", 32'(alu_valid), 32'd1);

        // Issue-time bypass from a same-cycle broadcast.
        cdb_valid = 1'b1;
        cdb_tag   = 4'd4;
        cdb_value = 32'd9;
        pushExp(OP_SUB, 32'd9, 32'd2, 32'h108, 32'd0, 4'd6);
        applyStimulus(OP_SUB, 32'h108, 32'd0, 32'hDEAD, 32'd2, 1'b1, 4'd4, 1'b0, 4'd0, 4'd6);
        cdb_valid = 1'b0;
        tick();
        checkOutput("bypass_dispatch", 32'(alu_valid), 32'd1);
        tick();

        // Fill every entry with pending work.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(OP_ADD, 32'h200 + 32'(i * 4), 32'd0, 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(OP_ADD, 32'h2F0, 32'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        checkOutput("ninth_ignored_full", 32'(full), 32'd1);
        checkOutput("ninth_no_dispatch", 32'(alu_valid), 32'd0);
        pushExp(OP_ADD, 32'h33, 32'd3, 32'h20C, 32'd0, 4'd3);
        broadcast(4'd11, 32'h33);
        checkOutput("wake_still_full", 32'(full), 32'd1);
        // This issue coincides with the freeing edge and must be dropped.
        applyStimulus(OP_ADD, 32'h2F4, 32'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
        checkOutput("wake_dispatch", 32'(alu_valid), 32'd1);
        checkOutput("freed_slot_not_reused", 32'(full), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_full", 32'(full), 32'd0);
        checkOutput("flush_alu_valid", 32'(alu_valid), 32'd0);

        // Three entries become ready together, then flush takes priority over dispatch.
        applyStimulus(OP_ADD, 32'h500, 32'd0, 32'd0, 32'd1, 1'b1, 4'd1, 1'b0, 4'd0, 4'd1);
        applyStimulus(OP_ADD, 32'h504, 32'd0, 32'd0, 32'd2, 1'b1, 4'd1, 1'b0, 4'd0, 4'd2);
        applyStimulus(OP_ADD, 32'h508, 32'd0, 32'd0, 32'd3, 1'b1, 4'd1, 1'b0, 4'd0, 4'd3);
        broadcast(4'd1, 32'h44);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush3_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("flush3_full", 32'(full), 32'd0);
        tick();
        checkOutput("flush3_none_after", 32'(alu_valid), 32'd0);
        tick();
        checkOutput("flush3_none_after2", 32'(alu_valid), 32'd0);

        // Both operands captured from a single broadcast.
        applyStimulus(OP_OR, 32'h600, 32'd0, 32'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd2, 4'd12);
        pushExp(OP_OR, 32'h55, 32'h55, 32'h600, 32'd0, 4'd12);
        broadcast(4'd2, 32'h55);
        tick();
        checkOutput("dual_dispatch", 32'(alu_valid), 32'd1);
        tick();

        // Stall with a ready entry waiting: everything holds for three cycles.
        pushExp(OP_ADDI, 32'hA1, 32'd0, 32'h300, 32'h11, 4'd1);
        applyStimulus(OP_ADDI, 32'h300, 32'h11, 32'hA1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        pushExp(OP_ADD, 32'hB1, 32'hB2, 32'h304, 32'd0, 4'd2);
        applyStimulus(OP_ADD, 32'h304, 32'd0, 32'hB1, 32'hB2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        checkOutput("stall_pre_dest", 32'(alu_dest), 32'd1);
        rdy_in = 1'b0;
        driveIssue(OP_SUB, 32'h308, 32'd0, 32'hC, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_alu_valid", 32'(alu_valid), 32'd1);
            checkOutput("stall_alu_dest", 32'(alu_dest), 32'd1);
            checkOutput("stall_alu_rs1", alu_rs1, 32'hA1);
        end
        issue_valid = 1'b0;
        rdy_in = 1'b1;
        tick();
        checkOutput("resume_alu_dest", 32'(alu_dest), 32'd2);
        tick();
        checkOutput("resume_then_idle", 32'(alu_valid), 32'd0);

        // Reset mid-flight: one dispatch visible, another entry ready.
        pushExp(OP_ADDI, 32'h77, 32'd0, 32'h400, 32'd1, 4'd7);
        applyStimulus(OP_ADDI, 32'h400, 32'd1, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        applyStimulus(OP_ADD, 32'h404, 32'd0, 32'h88, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("async_rst_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("async_rst_alu_rs1", alu_rs1, 32'd0);
        checkOutput("async_rst_alu_dest", 32'(alu_dest), 32'd0);
        tick();
        rst_in = 1'b1;
        tick();
        checkOutput("post_rst_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("post_rst_full", 32'(full), 32'd0);
        tick();
        checkOutput("post_rst_no_dispatch", 32'(alu_valid), 32'd0);

        tick();
        checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter RS_SIZE, 8: number of reservation-station entries.
REQ-002 Parameter TAG_W, 4: ROB tag width.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 flush  input  1  mispredict flush; clears station.
REQ-007 issue_valid  input  1  new instruction present.
REQ-008 issue_op  input  OPENUM width  operation enum.
REQ-009 issue_pc, issue_imm  input  32 each  instruction PC and immediate.
REQ-010 issue_vj, issue_vk  input  32 each  operand values when ready.
REQ-011 issue_qj_busy, issue_qk_busy  input  1 each  operand still pending.
REQ-012 issue_qj, issue_qk  input  TAG_W each  producer ROB tag of pending operand.
REQ-013 issue_dest  input  TAG_W  destination ROB tag.
REQ-014 full  output  1  no free entry (combinational from busy vector).
REQ-015 cdb_valid, cdb_tag, cdb_value  input  1/TAG_W/32  result broadcast.
REQ-016 alu_valid  output  1  dispatch valid to ALU (registered).
REQ-017 alu_op, alu_rs1, alu_rs2, alu_pc, alu_imm, alu_dest  output  registered operands to ALU.

Function
REQ-018 Per entry: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, pc, imm, dest.
REQ-019 Issue allocates the lowest-index free entry when issue_valid && !full && rdy_in && !flush.
REQ-020 Issue while full shall be ignored; entries unchanged.
REQ-021 Issue-time bypass: pending operand whose tag equals cdb_tag with cdb_valid in the same cycle is stored ready with cdb_value.
REQ-022 Each cycle, every busy entry with a pending operand matching a valid cdb_tag captures cdb_value and clears that busy flag; both operands may capture on one broadcast.
REQ-023 Entry is ready when busy && !qj_busy && !qk_busy, evaluated on registered state; a newly issued entry is never dispatched in its issue cycle.
REQ-024 Each cycle, the lowest-index ready entry is dispatched: outputs load at the edge, alu_valid=1, entry freed at that edge; none ready -> alu_valid=0 next cycle.
REQ-025 Dispatch latency: ready at cycle N -> alu_valid high in cycle N+1; one dispatch per cycle maximum.
REQ-026 Dispatch and issue in the same cycle are independent; the freed slot is not reusable until the next cycle (full evaluated pre-edge).
REQ-027 flush: at the edge, all busy cleared and alu_valid=0; flush dominates issue, CDB capture and dispatch.
REQ-028 rdy_in low: all registers hold, including alu_valid and outputs; ALU consumes only when rdy_in high.
REQ-029 alu_rs2 carries vk; imm passed unmodified; no arithmetic performed in this block.

Reset
REQ-030 rst_in low asynchronously clears every busy bit, alu_valid=0, all alu_* data outputs=0; full=0 consequently.
REQ-031 Reset asserted mid-operation discards all entries and pending dispatch, with no partial result visible after release.

Structure
REQ-032 OPENUM width/encodings, TAG_W, RS_SIZE and DATA/ADDR widths shall live in the shared defines package.
REQ-033 Sub-module rs_select (lowest-index priority encoder, RS_SIZE in, index+found out) shall be instantiated twice: free-slot and ready-entry selection.

Verification
REQ-034 Issue ADDI vj=5 imm=7 both ready, dest=3 -> alu_valid next cycle, alu_rs1=5, alu_imm=7, alu_dest=3; entry freed.
REQ-035 Issue ADD qj=2 pending, vk=1; later cdb tag=2 value=10 -> dispatch cycle after broadcast, alu_rs1=10, alu_rs2=1.
REQ-036 Issue with qj=4 pending while cdb_valid tag=4 value=9 same cycle -> dispatched next cycle with alu_rs1=9.
REQ-037 Fill 8 pending entries -> full=1; 9th issue ignored; one CDB wake-up and dispatch -> full=0 the cycle after the freeing edge.
REQ-038 Three ready entries plus flush in the same cycle -> alu_valid=0 next cycle, full=0, nothing dispatched afterward.
REQ-039 rdy_in low for 3 cycles with ready entries -> no state change, alu_* held; dispatch resumes the first cycle rdy_in is high.
